// File: rtl/huffman_code_assigner.sv
// Canonical Huffman code assigner: collects per-symbol code lengths, derives first codes per
// length, then writes a bit-reversed {code, length} table for an LSB-first deflate bit packer.
module huffman_code_assigner #(
  parameter int NUMCODES  = 288,
  parameter int CODEBITS  = 5,
  parameter int BITLENGTH = 15,
  localparam int AW = (NUMCODES > 2) ? $clog2(NUMCODES - 1) : 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 istart,
  input  logic                 wren,
  input  logic [AW-1:0]        wraddr,
  input  logic [CODEBITS-1:0]  wrdata,
  input  logic                 run,
  output logic                 done,
  output logic                 err,
  input  logic [AW-1:0]        rdaddr,
  output logic [BITLENGTH-1:0] rdcode,
  output logic [CODEBITS-1:0]  rdlen
);

  localparam int CW = $clog2(NUMCODES + 1);
  localparam int LW = $clog2(BITLENGTH + 1);
  localparam int NW = BITLENGTH + 1;
  localparam int SW = NW + CW + 1;
  localparam int TW = BITLENGTH + CODEBITS;

  typedef enum logic [1:0] {S_IDLE, S_NEXTCODE, S_ASSIGN, S_DONE} state_t;

  state_t              r_state;
  logic [LW-1:0]       r_b;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       r_blcount  [0:BITLENGTH];
  logic [NW-1:0]       r_nextcode [0:BITLENGTH];
  logic                r_err;
  logic [CODEBITS-1:0] r_len_ram  [0:NUMCODES-1];
  logic [TW-1:0]       r_tbl      [0:NUMCODES-1];
  logic [CODEBITS-1:0] r_lq;

  logic                w_wr_acc;
  logic                w_wr_inrange;
  logic [LW-1:0]       w_wr_idx;
  logic [LW-1:0]       w_b_prev;
  logic [CW-1:0]       w_bc_prev;
  logic [SW-1:0]       w_nc_full;
  logic                w_over;
  logic                w_lq_valid;
  logic [LW-1:0]       w_lq_idx;
  logic [NW-1:0]       w_nc_sel;
  logic                w_tbl_we;
  logic [AW-1:0]       w_tbl_addr;
  logic [TW-1:0]       w_tbl_data;

  // Reverse the low len bits of code; bits at or above len come out zero.
  function automatic logic [BITLENGTH-1:0] rev_code(input logic [NW-1:0] code,
                                                    input logic [CODEBITS-1:0] len);
    logic [NW-1:0] masked;
    logic [NW-1:0] full;
    masked = code & ~({NW{1'b1}} << len);
    for (int i = 0; i < NW; i++) full[i] = masked[NW-1-i];
    return BITLENGTH'(full >> (CODEBITS'(NW) - len));
  endfunction

  assign w_wr_acc     = wren & (r_state == S_IDLE) & ~istart & (int'(wraddr) < NUMCODES);
  assign w_wr_inrange = (wrdata != '0) && (wrdata <= CODEBITS'(BITLENGTH));
  assign w_wr_idx     = wrdata[LW-1:0];

  assign w_b_prev  = r_b - LW'(1);
  assign w_bc_prev = (w_b_prev == '0) ? '0 : r_blcount[w_b_prev];
  assign w_nc_full = (SW'(r_nextcode[w_b_prev]) + SW'(w_bc_prev)) << 1;
  assign w_over    = (w_nc_full + SW'(r_blcount[r_b])) > (SW'(1) << r_b);

  // Lengths above BITLENGTH are stored but behave as unused symbols here.
  assign w_lq_valid = (r_lq != '0) && (r_lq <= CODEBITS'(BITLENGTH));
  assign w_lq_idx   = r_lq[LW-1:0];
  assign w_nc_sel   = r_nextcode[w_lq_idx];

  always_comb begin
    w_tbl_we   = 1'b0;
    w_tbl_addr = AW'(r_cnt - CW'(1));
    w_tbl_data = '0;
    if ((r_state == S_ASSIGN) && run && (r_cnt != '0)) begin
      w_tbl_we = 1'b1;
      if (w_lq_valid) w_tbl_data = {rev_code(w_nc_sel, r_lq), r_lq};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_err   <= 1'b0;
      r_b     <= '0;
      r_cnt   <= '0;
      for (int i = 0; i <= BITLENGTH; i++) begin
        r_blcount[i]  <= '0;
        r_nextcode[i] <= '0;
      end
    end else if (istart) begin
      r_state <= S_IDLE;
      r_err   <= 1'b0;
      r_b     <= '0;
      r_cnt   <= '0;
      for (int i = 0; i <= BITLENGTH; i++) begin
        r_blcount[i]  <= '0;
        r_nextcode[i] <= '0;
      end
    end else begin
      if (w_wr_acc) begin
        if (w_wr_inrange) r_blcount[w_wr_idx] <= r_blcount[w_wr_idx] + CW'(1);
        else if (wrdata != '0) r_err <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (run) begin
            r_state <= S_NEXTCODE;
            r_b     <= LW'(1);
          end
        end
        S_NEXTCODE: begin
          if (!run) begin
            r_state <= S_IDLE;
          end else begin
            r_nextcode[r_b] <= w_nc_full[NW-1:0];
            if (w_over) r_err <= 1'b1;
            if (r_b == LW'(BITLENGTH)) begin
              r_state <= S_ASSIGN;
              r_cnt   <= '0;
            end else begin
              r_b <= r_b + LW'(1);
            end
          end
        end
        S_ASSIGN: begin
          if (!run) begin
            r_state <= S_IDLE;
          end else begin
            if ((r_cnt != '0) && w_lq_valid) r_nextcode[w_lq_idx] <= w_nc_sel + NW'(1);
            if (r_cnt == CW'(NUMCODES)) r_state <= S_DONE;
            else r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          if (!run) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Length RAM reads one symbol ahead of the table write.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_len_ram[wraddr] <= wrdata;
    if (r_cnt < CW'(NUMCODES)) r_lq <= r_len_ram[AW'(r_cnt)];
  end

  always_ff @(posedge clk) begin
    if (w_tbl_we) r_tbl[w_tbl_addr] <= w_tbl_data;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rdcode <= '0;
      rdlen  <= '0;
    end else if (int'(rdaddr) < NUMCODES) begin
      {rdcode, rdlen} <= r_tbl[rdaddr];
    end
  end

  assign done = (r_state == S_DONE) & run;
  assign err  = r_err;

endmodule

// File: tb/tb_huffman_code_assigner.sv
// Randomized bench for huffman_code_assigner: an 8-symbol and a 288-symbol instance are checked
// against a canonical-code model that assigns codes by walking lengths in ascending order.
module tb_huffman_code_assigner;

  logic        clk = 1'b0;
  logic        rstn, istart, wren, run, sel;
  logic [8:0]  wraddr, rdaddr;
  logic [4:0]  wrdata;
  logic        done8, err8, done288, err288;
  logic [14:0] rdcode8, rdcode288;
  logic [4:0]  rdlen8, rdlen288;
  logic        done_m, err_m;
  logic [14:0] rdcode_m;
  logic [4:0]  rdlen_m;

  int n_checks = 0;
  int n_fail   = 0;

  int lens [288];
  int saved[288];
  int exp_code[288];
  int exp_len [288];
  int nsym;
  bit exp_err, exp_over;

  always #5 clk = ~clk;

  huffman_code_assigner #(.NUMCODES(8)) u_dut8 (
    .clk(clk), .rstn(rstn), .istart(istart & ~sel), .wren(wren & ~sel),
    .wraddr(wraddr[2:0]), .wrdata(wrdata), .run(run & ~sel), .done(done8), .err(err8),
    .rdaddr(rdaddr[2:0]), .rdcode(rdcode8), .rdlen(rdlen8));

  huffman_code_assigner u_dut288 (
    .clk(clk), .rstn(rstn), .istart(istart & sel), .wren(wren & sel),
    .wraddr(wraddr), .wrdata(wrdata), .run(run & sel), .done(done288), .err(err288),
    .rdaddr(rdaddr), .rdcode(rdcode288), .rdlen(rdlen288));

  assign done_m   = sel ? done288   : done8;
  assign err_m    = sel ? err288    : err8;
  assign rdcode_m = sel ? rdcode288 : rdcode8;
  assign rdlen_m  = sel ? rdlen288  : rdlen8;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int kraft();
    int k = 0;
    for (int s = 0; s < nsym; s++)
      if (lens[s] >= 1 && lens[s] <= 15) k += 1 << (15 - lens[s]);
    return k;
  endfunction

  function automatic int rev(input int v, input int l);
    int r = 0;
    for (int i = 0; i < l; i++) if (((v >> i) & 1) != 0) r |= 1 << (l - 1 - i);
    return r;
  endfunction

  // Canonical codes: shorter lengths first, ties broken by symbol index.
  function automatic void model();
    int c = 0;
    exp_over = (kraft() > 32768);
    exp_err  = exp_over;
    for (int s = 0; s < nsym; s++) begin
      if (lens[s] > 15) exp_err = 1'b1;
      exp_code[s] = 0;
      exp_len[s]  = (lens[s] >= 1 && lens[s] <= 15) ? lens[s] : 0;
    end
    for (int l = 1; l <= 15; l++) begin
      for (int s = 0; s < nsym; s++)
        if (lens[s] == l) begin
          exp_code[s] = rev(c, l);
          c++;
        end
      c = c << 1;
    end
  endfunction

  function automatic void gen_rand();
    int s;
    for (int i = 0; i < nsym; i++)
      lens[i] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 9));
    while (kraft() > 32768) begin
      s = int'($urandom_range(0, nsym - 1));
      if (lens[s] >= 1 && lens[s] <= 14) lens[s]++;
    end
  endfunction

  task automatic do_istart();
    istart = 1'b1;
    tick();
    istart = 1'b0;
  endtask

  task automatic write_all();
    for (int s = 0; s < nsym; s++) begin
      wren = 1'b1; wraddr = 9'(s); wrdata = 5'(lens[s]);
      tick();
    end
    wren = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int already, input int exp_lat);
    int cnt = already;
    while (!done_m && cnt < 2000) begin
      tick();
      cnt++;
    end
    chk({tag, " latency"}, cnt, exp_lat);
  endtask

  task automatic build(input string tag);
    run = 1'b1;
    wait_done(tag, 0, nsym + 17);
  endtask

  task automatic check_table(input string tag);
    model();
    chk({tag, " err"}, err_m, exp_err);
    if (!exp_over)
      for (int s = 0; s < nsym; s++) begin
        rdaddr = 9'(s);
        tick();
        chk($sformatf("%s len[%0d]", tag, s), rdlen_m, exp_len[s]);
        chk($sformatf("%s code[%0d]", tag, s), rdcode_m, exp_code[s]);
      end
  endtask

  task automatic spot(input string tag, input int s, input int code, input int len);
    rdaddr = 9'(s);
    tick();
    chk({tag, " code"}, rdcode_m, code);
    chk({tag, " len"}, rdlen_m, len);
  endtask

  task automatic stop_run();
    run = 1'b0;
    tick();
    chk("run drop done", done_m, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; istart = 1'b0; wren = 1'b0; run = 1'b0; sel = 1'b0;
    wraddr = '0; wrdata = '0; rdaddr = '0;
    repeat (3) tick();
    chk("rst done8", done8, 0);
    chk("rst err8", err8, 0);
    chk("rst rdcode8", rdcode8, 0);
    chk("rst rdlen8", rdlen8, 0);
    chk("rst done288", done288, 0);
    chk("rst err288", err288, 0);
    chk("rst rdcode288", rdcode288, 0);
    chk("rst rdlen288", rdlen288, 0);
    rstn = 1'b1;
    tick();

    // RFC example on the 8-symbol instance
    sel = 1'b0; nsym = 8;
    do_istart();
    lens[0:7] = '{3, 3, 3, 3, 3, 2, 4, 4};
    write_all();
    build("T1");
    check_table("T1");
    spot("T1 G", 6, 7, 4);
    spot("T1 H", 7, 15, 4);
    stop_run();

    // Fixed literal/length table on the 288-symbol instance
    sel = 1'b1; nsym = 288;
    do_istart();
    for (int s = 0; s < 288; s++)
      lens[s] = (s < 144) ? 8 : (s < 256) ? 9 : (s < 280) ? 7 : 8;
    write_all();
    build("T2");
    check_table("T2");
    spot("T2 s0", 0, 'h0C, 8);
    spot("T2 s144", 144, 'h13, 9);
    spot("T2 s256", 256, 'h00, 7);
    spot("T2 s280", 280, 'h03, 8);
    stop_run();

    // Oversubscribed set, then a lone length-1 symbol
    sel = 1'b0; nsym = 8;
    do_istart();
    lens[0:7] = '{1, 0, 0, 1, 0, 1, 0, 0};
    write_all();
    build("T3a");
    chk("T3a err", err_m, 1);
    stop_run();
    do_istart();
    for (int s = 0; s < 8; s++) lens[s] = 0;
    lens[$urandom_range(0, 7)] = 1;
    write_all();
    build("T3b");
    check_table("T3b");
    stop_run();

    // Zero-length and out-of-range lengths
    do_istart();
    gen_rand();
    lens[2] = 0;
    lens[5] = 16;
    write_all();
    build("T4");
    check_table("T4");
    chk("T4 err set", err_m, 1);
    stop_run();

    // Abort mid-ASSIGN, rebuild, then abort from DONE and rebuild again
    sel = 1'b1; nsym = 288;
    do_istart();
    gen_rand();
    write_all();
    run = 1'b1;
    repeat (115) tick();
    chk("T5 mid done", done_m, 0);
    stop_run();
    build("T5 rebuild");
    check_table("T5 rebuild");
    stop_run();
    build("T5 again");
    check_table("T5 again");
    stop_run();

    // Reset applied mid-NEXTCODE
    sel = 1'b0; nsym = 8;
    do_istart();
    gen_rand();
    write_all();
    run = 1'b1;
    repeat (5) tick();
    rstn = 1'b0;
    tick();
    chk("T6 rst done", done_m, 0);
    chk("T6 rst err", err_m, 0);
    rstn = 1'b1; run = 1'b0;
    tick();
    gen_rand();
    write_all();
    build("T6 after rst");
    check_table("T6 after rst");
    stop_run();

    // istart applied mid-NEXTCODE
    do_istart();
    gen_rand();
    write_all();
    run = 1'b1;
    repeat (6) tick();
    istart = 1'b1;
    tick();
    istart = 1'b0; run = 1'b0;
    chk("T6 istart done", done_m, 0);
    tick();
    gen_rand();
    write_all();
    build("T6 after istart");
    check_table("T6 after istart");
    stop_run();

    // Writes during ASSIGN must be ignored
    do_istart();
    gen_rand();
    write_all();
    saved = lens;
    run = 1'b1;
    repeat (18) tick();
    wren = 1'b1; wraddr = 9'd3; wrdata = 5'((lens[3] % 15) + 1);
    tick();
    wren = 1'b0;
    wait_done("T6 wren", 19, 25);
    lens = saved;
    check_table("T6 wren");
    stop_run();
    build("T6 wren rebuild");
    check_table("T6 wren rebuild");
    stop_run();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
